// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the control sequencer: instruction field positions,
// opcode values, FSM state encoding and strobe/class bundles.
package cpu_ctrl_pkg;

   localparam int unsigned IR_W     = 32;
   localparam int unsigned OPCODE_W = 5;

   // Instruction field bit positions
   localparam int unsigned OPC_MSB = 31;
   localparam int unsigned OPC_LSB = 27;
   localparam int unsigned RA_MSB  = 26;
   localparam int unsigned RA_LSB  = 23;
   localparam int unsigned RB_MSB  = 22;
   localparam int unsigned RB_LSB  = 19;
   localparam int unsigned RC_MSB  = 18;
   localparam int unsigned RC_LSB  = 15;

   // Opcodes
   localparam logic [OPCODE_W-1:0] OPC_ADD  = 5'b00011;
   localparam logic [OPCODE_W-1:0] OPC_SUB  = 5'b00100;
   localparam logic [OPCODE_W-1:0] OPC_AND  = 5'b00101;
   localparam logic [OPCODE_W-1:0] OPC_OR   = 5'b00110;
   localparam logic [OPCODE_W-1:0] OPC_SHR  = 5'b00111;
   localparam logic [OPCODE_W-1:0] OPC_SHL  = 5'b01000;
   localparam logic [OPCODE_W-1:0] OPC_ROR  = 5'b01001;
   localparam logic [OPCODE_W-1:0] OPC_ROL  = 5'b01010;
   localparam logic [OPCODE_W-1:0] OPC_MUL  = 5'b01111;
   localparam logic [OPCODE_W-1:0] OPC_DIV  = 5'b10000;
   localparam logic [OPCODE_W-1:0] OPC_NEG  = 5'b10001;
   localparam logic [OPCODE_W-1:0] OPC_NOT  = 5'b10010;
   localparam logic [OPCODE_W-1:0] OPC_NOP  = 5'b11010;
   localparam logic [OPCODE_W-1:0] OPC_HALT = 5'b11011;

   typedef enum logic [3:0] {
      RST_ST = 4'd0,
      FETCH0 = 4'd1,
      FETCH1 = 4'd2,
      FETCH2 = 4'd3,
      T3     = 4'd4,
      T4     = 4'd5,
      T5     = 4'd6,
      T6     = 4'd7,
      HALT   = 4'd8
   } state_e;

   // Datapath strobe bundle driven by the sequencer
   typedef struct packed {
      logic PCout;
      logic Zlowout;
      logic Zhighout;
      logic MDRout;
      logic Rout;
      logic PCin;
      logic MARin;
      logic MDRin;
      logic IRin;
      logic Yin;
      logic Zin;
      logic Rin;
      logic HIin;
      logic LOin;
      logic IncPC;
      logic Read;
      logic Gra;
      logic Grb;
      logic Grc;
   } ctrl_strobes_t;

   // One-hot instruction class from the opcode decoder
   typedef struct packed {
      logic three_op;
      logic two_op;
      logic muldiv;
      logic nop;
      logic halt;
      logic illegal;
   } op_class_t;

   function automatic logic [OPCODE_W-1:0] ir_opcode(input logic [IR_W-1:0] ir);
      return ir[OPC_MSB:OPC_LSB];
   endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Sequencer <-> datapath bundle.
//   master (sequencer): reads IR, mem_ready, stop; drives strobes, operation,
//                       run, illegal_op, bus_error.
//   slave  (datapath) : the mirror image.
interface control_sequencer_if #(
   parameter int unsigned OP_W = 5
);
   import cpu_ctrl_pkg::*;

   logic [IR_W-1:0] IR;
   logic            mem_ready;
   logic            stop;

   logic PCout, Zlowout, Zhighout, MDRout, Rout;
   logic PCin, MARin, MDRin, IRin, Yin, Zin, Rin, HIin, LOin;
   logic IncPC, Read;
   logic Gra, Grb, Grc;
   logic [OP_W-1:0] operation;
   logic run;
   logic illegal_op;
   logic bus_error;

   modport master (
      input  IR, mem_ready, stop,
      output PCout, Zlowout, Zhighout, MDRout, Rout,
      output PCin, MARin, MDRin, IRin, Yin, Zin, Rin, HIin, LOin,
      output IncPC, Read, Gra, Grb, Grc,
      output operation, run, illegal_op, bus_error
   );

   modport slave (
      output IR, mem_ready, stop,
      input  PCout, Zlowout, Zhighout, MDRout, Rout,
      input  PCin, MARin, MDRin, IRin, Yin, Zin, Rin, HIin, LOin,
      input  IncPC, Read, Gra, Grb, Grc,
      input  operation, run, illegal_op, bus_error
   );
endinterface

// File: rtl/opcode_class_decode.sv
// Combinational opcode classifier.
//   opcode_i   : IR[31:27]
//   op_class_o : one-hot {three_op, two_op, muldiv, nop, halt, illegal}
module opcode_class_decode
   import cpu_ctrl_pkg::*;
(
   input  logic [OPCODE_W-1:0] opcode_i,
   output op_class_t           op_class_o
);

   always_comb begin
      op_class_o = '0;
      case (opcode_i)
         OPC_ADD, OPC_SUB, OPC_AND, OPC_OR,
         OPC_SHR, OPC_SHL, OPC_ROR, OPC_ROL: op_class_o.three_op = 1'b1;
         OPC_NEG, OPC_NOT:                   op_class_o.two_op   = 1'b1;
         OPC_MUL, OPC_DIV:                   op_class_o.muldiv   = 1'b1;
         OPC_NOP:                            op_class_o.nop      = 1'b1;
         OPC_HALT:                           op_class_o.halt     = 1'b1;
         default:                            op_class_o.illegal  = 1'b1;
      endcase
   end

endmodule

// File: rtl/control_sequencer.sv
// Moore control sequencer for instruction fetch and register-register ALU ops.
//   Clock : rising-edge clock
//   clear : asynchronous active-high reset
//   bus   : master side of control_sequencer_if (IR/mem_ready/stop in,
//           datapath strobes, operation, run, illegal_op, bus_error out)
// Strobes are a decode of the state register (plus IR in T3..T6) so they hold
// for the whole state cycle and vanish the instant clear asserts.
module control_sequencer
   import cpu_ctrl_pkg::*;
#(
   parameter int unsigned OP_W     = 5,
   parameter int unsigned WAIT_MAX = 15
) (
   input  logic               Clock,
   input  logic               clear,
   control_sequencer_if.master bus
);

   localparam int unsigned CNT_W = $clog2(WAIT_MAX + 1);

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     wait_cnt_q, wait_cnt_d;
   logic                 bus_error_q, bus_error_d;

   logic [OPCODE_W-1:0]  opcode;
   op_class_t            opc;
   ctrl_strobes_t        strb_c;
   logic [OP_W-1:0]      operation_c;
   logic                 run_c;
   logic                 illegal_c;

   assign opcode = ir_opcode(bus.IR);

   opcode_class_decode u_decode (
      .opcode_i   (opcode),
      .op_class_o (opc)
   );

   // State, fetch wait counter and sticky bus error
   always_ff @(posedge Clock or posedge clear) begin
      if (clear) begin
         state_q     <= RST_ST;
         wait_cnt_q  <= '0;
         bus_error_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         bus_error_q <= bus_error_d;
      end
   end

   // Next-state logic; the wait counter is zero outside FETCH1 so it restarts on entry
   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = '0;
      bus_error_d = bus_error_q;
      case (state_q)
         RST_ST: state_d = FETCH0;
         FETCH0: state_d = bus.stop ? HALT : FETCH1;
         FETCH1: begin
            if (bus.mem_ready) begin
               state_d = FETCH2;
            end else if (wait_cnt_q >= CNT_W'(WAIT_MAX - 1)) begin
               // last allowed cycle without data: mem_ready above takes priority
               bus_error_d = 1'b1;
               state_d     = HALT;
            end else begin
               wait_cnt_d = (wait_cnt_q < CNT_W'(WAIT_MAX)) ? wait_cnt_q + CNT_W'(1)
                                                            : wait_cnt_q;
            end
         end
         FETCH2: state_d = T3;
         T3: begin
            if (opc.three_op || opc.two_op || opc.muldiv) state_d = T4;
            else if (opc.halt)                            state_d = HALT;
            else                                          state_d = FETCH0;
         end
         T4:      state_d = (opc.three_op || opc.muldiv) ? T5 : FETCH0;
         T5:      state_d = opc.muldiv ? T6 : FETCH0;
         T6:      state_d = FETCH0;
         HALT:    state_d = HALT;
         default: state_d = RST_ST;
      endcase
   end

   // Strobe decode of the current state
   always_comb begin
      strb_c      = '0;
      operation_c = '0;
      illegal_c   = 1'b0;
      run_c       = 1'b1;
      case (state_q)
         RST_ST, HALT: run_c = 1'b0;
         FETCH0: begin
            strb_c.PCout = 1'b1;
            strb_c.MARin = 1'b1;
            strb_c.IncPC = 1'b1;
            strb_c.Zin   = 1'b1;
         end
         FETCH1: begin
            strb_c.Zlowout = 1'b1;
            strb_c.Read    = 1'b1;
            strb_c.MDRin   = 1'b1;
            // PC write-back only once, in the first wait cycle
            strb_c.PCin    = (wait_cnt_q == '0);
         end
         FETCH2: begin
            strb_c.MDRout = 1'b1;
            strb_c.IRin   = 1'b1;
         end
         T3: begin
            if (opc.three_op) begin
               strb_c.Grb  = 1'b1;
               strb_c.Rout = 1'b1;
               strb_c.Yin  = 1'b1;
            end else if (opc.two_op) begin
               strb_c.Grb  = 1'b1;
               strb_c.Rout = 1'b1;
               strb_c.Zin  = 1'b1;
               operation_c = OP_W'(opcode);
            end else if (opc.muldiv) begin
               strb_c.Gra  = 1'b1;
               strb_c.Rout = 1'b1;
               strb_c.Yin  = 1'b1;
            end else if (opc.illegal) begin
               illegal_c = 1'b1;
            end
         end
         T4: begin
            if (opc.three_op) begin
               strb_c.Grc  = 1'b1;
               strb_c.Rout = 1'b1;
               strb_c.Zin  = 1'b1;
               operation_c = OP_W'(opcode);
            end else if (opc.two_op) begin
               strb_c.Zlowout = 1'b1;
               strb_c.Gra     = 1'b1;
               strb_c.Rin     = 1'b1;
            end else if (opc.muldiv) begin
               strb_c.Grb  = 1'b1;
               strb_c.Rout = 1'b1;
               strb_c.Zin  = 1'b1;
               operation_c = OP_W'(opcode);
            end
         end
         T5: begin
            if (opc.three_op) begin
               strb_c.Zlowout = 1'b1;
               strb_c.Gra     = 1'b1;
               strb_c.Rin     = 1'b1;
            end else if (opc.muldiv) begin
               strb_c.Zlowout = 1'b1;
               strb_c.LOin    = 1'b1;
            end
         end
         T6: begin
            if (opc.muldiv) begin
               strb_c.Zhighout = 1'b1;
               strb_c.HIin     = 1'b1;
            end
         end
         default: run_c = 1'b0;
      endcase
   end

   assign bus.PCout      = strb_c.PCout;
   assign bus.Zlowout    = strb_c.Zlowout;
   assign bus.Zhighout   = strb_c.Zhighout;
   assign bus.MDRout     = strb_c.MDRout;
   assign bus.Rout       = strb_c.Rout;
   assign bus.PCin       = strb_c.PCin;
   assign bus.MARin      = strb_c.MARin;
   assign bus.MDRin      = strb_c.MDRin;
   assign bus.IRin       = strb_c.IRin;
   assign bus.Yin        = strb_c.Yin;
   assign bus.Zin        = strb_c.Zin;
   assign bus.Rin        = strb_c.Rin;
   assign bus.HIin       = strb_c.HIin;
   assign bus.LOin       = strb_c.LOin;
   assign bus.IncPC      = strb_c.IncPC;
   assign bus.Read       = strb_c.Read;
   assign bus.Gra        = strb_c.Gra;
   assign bus.Grb        = strb_c.Grb;
   assign bus.Grc        = strb_c.Grc;
   assign bus.operation  = operation_c;
   assign bus.run        = run_c;
   assign bus.illegal_op = illegal_c;
   assign bus.bus_error  = bus_error_q;

endmodule
